// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, flag bit positions and sequencer states for alu_seq_core.
// Revision    : 1.0
// ============================================================================
package alu_pkg;
    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_INC   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_DEP   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_ORA   = 5'h05;
    localparam logic [4:0] OP_EOR   = 5'h06;
    localparam logic [4:0] OP_LDA   = 5'h07;
    localparam logic [4:0] OP_EXT   = 5'h08;
    localparam logic [4:0] OP_BSW   = 5'h09;
    localparam logic [4:0] OP_ROR   = 5'h0A;
    localparam logic [4:0] OP_ROL   = 5'h0B;
    localparam logic [4:0] OP_LDZ   = 5'h0C;
    localparam logic [4:0] OP_MUL   = 5'h10;
    localparam logic [4:0] OP_MULHU = 5'h11;
    localparam logic [4:0] OP_DIVU  = 5'h12;
    localparam logic [4:0] OP_REMU  = 5'h13;

    localparam logic [1:0] MD_MUL   = 2'd0;
    localparam logic [1:0] MD_MULHU = 2'd1;
    localparam logic [1:0] MD_DIVU  = 2'd2;
    localparam logic [1:0] MD_REMU  = 2'd3;

    localparam int FL_C = 0;
    localparam int FL_V = 1;
    localparam int FL_Z = 2;
    localparam int FL_N = 3;
    localparam int FL_A = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Radix-2 iterative unsigned multiply / restoring divide datapath.
// Revision    : 1.0
// ============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_step,
    input  logic [1:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_result,
    output logic         o_carry
);
    // r_acc = {high/remainder, low/quotient}; r_opnd = multiplicand or divisor
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic [1:0]     r_op;
    logic [W:0]     w_add;
    logic [W:0]     w_rem;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_next;

    always_comb begin
        w_add  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_rem  = {r_acc[2*W-1:W], r_acc[W-1]};
        w_diff = w_rem - {1'b0, r_opnd};
        if (!r_op[1])
            w_next = {w_add, r_acc[W-1:1]};
        else if (!w_diff[W])
            w_next = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
        else
            w_next = {w_rem[W-1:0], r_acc[W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_op   <= MD_MUL;
        end else if (i_start) begin
            r_acc  <= {{W{1'b0}}, i_a};
            r_opnd <= i_b;
            r_op   <= i_op;
        end else if (i_step) begin
            r_acc  <= w_next;
        end
    end

    // A zero divisor never fails the trial subtract: quotient all ones, remainder = dividend
    always_comb begin
        case (r_op)
            MD_MUL:   o_result = r_acc[W-1:0];
            MD_MULHU: o_result = r_acc[2*W-1:W];
            MD_DIVU:  o_result = r_acc[W-1:0];
            default:  o_result = r_acc[2*W-1:W];
        endcase
        o_carry = r_op[1] ? (r_opnd == '0) : (r_acc[2*W-1:W] != '0);
    end
endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_core
// Description : W-bit ALU with dual-read register bank, flags register and
//               handshake-stalled iterative multiply/divide.
// Revision    : 1.0
// ============================================================================
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int W         = 16,
    parameter int NREGS     = 8,
    parameter int FLAGS_IDX = 2,
    parameter int PC_IDX    = 3,
    localparam int RI       = $clog2(NREGS)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [4:0]    alu_f,
    input  logic [RI-1:0] a_idx,
    input  logic [RI-1:0] b_idx,
    input  logic [RI-1:0] d_idx,
    input  logic          carry_mask,
    input  logic          sel_inp,
    input  logic [W-1:0]  t_imm,
    input  logic          wr_reg,
    input  logic          wr_flags,
    input  logic          wr_back_addr,
    output logic [W-1:0]  d_val,
    output logic [W-1:0]  flags,
    output logic [W-1:0]  mar_val,
    output logic [W-1:0]  mem_data,
    output logic          wr_pc,
    output logic          res_valid,
    output logic          busy
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  r_bank [NREGS];
    logic [W-1:0]  r_sf;
    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_cnt;
    logic [RI-1:0] r_dst;
    logic          r_wr_reg;
    logic          r_wr_flags;

    logic [W-1:0]  w_a, w_b, w_s;
    logic          w_cin, w_nborrow, w_is_md, w_start, w_step;
    logic [RI-1:0] w_dst_sel;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_alu_res, w_alu_fw, w_md_res, w_md_fw;
    logic          w_fc, w_fv, w_fa, w_md_c;
    logic          w_commit, w_c_wr_reg, w_c_wr_flags;
    logic [W-1:0]  w_c_res, w_c_fw;
    logic [RI-1:0] w_c_dst;

    assign w_a       = (a_idx == RI'(FLAGS_IDX)) ? r_sf : r_bank[a_idx];
    assign w_b       = (b_idx == RI'(FLAGS_IDX)) ? r_sf : r_bank[b_idx];
    assign w_s       = sel_inp ? w_b : t_imm;
    assign w_cin     = carry_mask & r_sf[FL_C];
    // Subtract treats C as "no borrow": unmasked subtract adds the full +1
    assign w_nborrow = carry_mask ? r_sf[FL_C] : 1'b1;
    assign w_is_md   = (alu_f[4:2] == 3'b100);
    assign w_start   = (r_state == ST_IDLE) & op_valid & w_is_md;
    assign w_dst_sel = wr_back_addr ? a_idx : d_idx;
    assign mar_val   = w_a + t_imm;
    assign mem_data  = w_b;
    assign flags     = r_sf;

    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_fc      = 1'b0;
        w_fv      = 1'b0;
        w_fa      = 1'b0;
        case (alu_f)
            OP_ADD: begin
                w_sum     = {1'b0, w_a} + {1'b0, w_s} + {{W{1'b0}}, w_cin};
                w_alu_res = w_sum[W-1:0];
                w_fc      = w_sum[W];
                w_fv      = (w_a[W-1] == w_s[W-1]) && (w_alu_res[W-1] != w_a[W-1]);
            end
            OP_INC: begin
                w_sum     = {1'b0, w_b} + {{W{1'b0}}, 1'b1};
                w_alu_res = w_sum[W-1:0];
                w_fc      = w_sum[W];
                w_fv      = ~w_b[W-1] & w_alu_res[W-1];
            end
            OP_SUB: begin
                w_sum     = {1'b0, w_a} + {1'b0, ~w_s} + {{W{1'b0}}, w_nborrow};
                w_alu_res = w_sum[W-1:0];
                w_fc      = w_sum[W];
                w_fv      = (w_a[W-1] != w_s[W-1]) && (w_alu_res[W-1] != w_a[W-1]);
            end
            OP_DEP: begin
                w_fa      = |w_b;
                w_alu_res = w_b - {{(W-1){1'b0}}, w_fa};
                w_fc      = w_fa;
                w_fv      = w_b[W-1] & ~w_alu_res[W-1];
            end
            OP_AND: w_alu_res = w_a & w_s;
            OP_ORA: w_alu_res = w_a | w_s;
            OP_EOR: w_alu_res = w_a ^ w_s;
            OP_LDA: w_alu_res = w_s;
            OP_EXT: w_alu_res = {{(W-8){w_s[7]}}, w_s[7:0]};
            OP_BSW: begin
                w_alu_res       = w_s;
                w_alu_res[15:0] = {w_s[7:0], w_s[15:8]};
            end
            OP_ROR: begin
                w_alu_res = {w_cin, w_s[W-1:1]};
                w_fc      = w_s[0];
            end
            OP_ROL: begin
                w_alu_res = {w_s[W-2:0], w_cin};
                w_fc      = w_s[W-1];
            end
            default: ;
        endcase
    end

    assign w_alu_fw = {{(W-5){1'b0}}, w_fa, w_alu_res[W-1], (w_alu_res == '0), w_fv, w_fc};
    assign w_md_fw  = {{(W-5){1'b0}}, 1'b0, w_md_res[W-1], (w_md_res == '0), 1'b0, w_md_c};

    alu_muldiv_iter #(.W(W)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_op     (alu_f[1:0]),
        .i_a      (w_a),
        .i_b      (w_s),
        .o_result (w_md_res),
        .o_carry  (w_md_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready     = (r_state == ST_IDLE);
        busy         = ~op_ready;
        w_step       = (r_state == ST_RUN);
        w_commit     = 1'b0;
        w_c_res      = w_alu_res;
        w_c_fw       = w_alu_fw;
        w_c_dst      = w_dst_sel;
        w_c_wr_reg   = wr_reg;
        w_c_wr_flags = wr_flags;
        case (r_state)
            ST_IDLE: w_commit = op_valid & ~w_is_md;
            ST_DONE: begin
                w_commit     = 1'b1;
                w_c_res      = w_md_res;
                w_c_fw       = w_md_fw;
                w_c_dst      = r_dst;
                w_c_wr_reg   = r_wr_reg;
                w_c_wr_flags = r_wr_flags;
            end
            default: ;
        endcase
        res_valid = w_commit;
        wr_pc     = w_commit & w_c_wr_reg & (w_c_dst == RI'(PC_IDX));
        d_val     = (r_state == ST_IDLE) ? w_alu_res : w_md_res;
    end

    // Flag-word write wins over a register write aimed at the flags alias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sf       <= '0;
            r_cnt      <= '0;
            r_dst      <= '0;
            r_wr_reg   <= 1'b0;
            r_wr_flags <= 1'b0;
        end else begin
            if (w_commit && w_c_wr_flags)
                r_sf <= w_c_fw;
            else if (w_commit && w_c_wr_reg && (w_c_dst == RI'(FLAGS_IDX)))
                r_sf <= w_c_res;
            if (w_start) begin
                r_cnt      <= CW'(W-1);
                r_dst      <= w_dst_sel;
                r_wr_reg   <= wr_reg;
                r_wr_flags <= wr_flags;
            end else if (w_step) begin
                r_cnt      <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_c_wr_reg && (w_c_dst != RI'(FLAGS_IDX)))
            r_bank[w_c_dst] <= w_c_res;
    end
endmodule
`default_nettype wire
